// File: rtl/jk_excite_driver_if.sv
// Handshake and bank-drive bundle for jk_excite_driver.
//   tgt_valid/tgt_ready/tgt_data : target word handshake (requester -> driver)
//   q_fb                         : fed-back q of the external JK bank
//   j/k                          : J/K drive to the bank
//   done/err                     : completion pulse and sticky failure flag
// master = requester/bank side, slave = the driver block.
interface jk_excite_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             err;

  modport master (output tgt_valid, tgt_data, q_fb,
                  input  tgt_ready, j, k, done, err);
  modport slave  (input  tgt_valid, tgt_data, q_fb,
                  output tgt_ready, j, k, done, err);
endinterface

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: steers an external bank of WIDTH JK flip-flops to a
// requested word. Accepts a target in IDLE, drives one cycle of JK
// excitation (DRIVE), checks the bank in the following cycle (SETTLE) and
// retries up to MAX_RETRY times before flagging an error.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - jk_excite_driver_if slave: target handshake, q_fb in, j/k/done/err out
// All outputs are registered.

// Per-bit excitation: unchanged bits hold (J=K=0); changing bits either
// set/reset or toggle depending on TOGGLE_PREF.
module jk_excite_bit #(
  parameter int TOGGLE_PREF = 0
) (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (q != t) begin
      if (TOGGLE_PREF != 0) begin
        j = 1'b1;
        k = 1'b1;
      end else begin
        j = t;
        k = ~t;
      end
    end
  end
endmodule

module jk_excite_driver #(
  parameter int WIDTH       = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TOGGLE_PREF = 0
) (
  input  logic                clk,
  input  logic                rst,
  jk_excite_driver_if.slave   bus
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt_q, tgt_n;
  logic [RW-1:0]    cnt, cnt_n;
  logic             ready_q, ready_n;
  logic [WIDTH-1:0] j_q, j_n, k_q, k_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  // Excitation target: fresh data on acceptance, latched target on retry.
  logic [WIDTH-1:0] exc_tgt, exc_j, exc_k;
  assign exc_tgt = (state == IDLE) ? bus.tgt_data : tgt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit #(.TOGGLE_PREF(TOGGLE_PREF)) u_bit (
      .q (bus.q_fb[i]),
      .t (exc_tgt[i]),
      .j (exc_j[i]),
      .k (exc_k[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt_q   <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      tgt_q   <= tgt_n;
      cnt     <= cnt_n;
      ready_q <= ready_n;
      j_q     <= j_n;
      k_q     <= k_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic also produces the next registered output values, so
  // j/k/ready/done change on the same edge as the state they belong to.
  always_comb begin
    state_n = state;
    tgt_n   = tgt_q;
    cnt_n   = cnt;
    ready_n = 1'b0;
    j_n     = '0;
    k_n     = '0;
    done_n  = 1'b0;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (bus.tgt_valid && ready_q) begin
          tgt_n   = bus.tgt_data;
          cnt_n   = '0;
          err_n   = 1'b0;
          ready_n = 1'b0;
          j_n     = exc_j;
          k_n     = exc_k;
          state_n = DRIVE;
        end
      end
      DRIVE: state_n = SETTLE;
      SETTLE: begin
        if (bus.q_fb == tgt_q) begin
          done_n  = 1'b1;
          err_n   = 1'b0;
          ready_n = 1'b1;
          state_n = IDLE;
        end else if (cnt < RW'(MAX_RETRY)) begin
          cnt_n   = cnt + RW'(1);
          j_n     = exc_j;
          k_n     = exc_k;
          state_n = DRIVE;
        end else begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          ready_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.tgt_ready = ready_q;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (set/reset and toggle excitation)
// share one stimulus stream, each driving its own behavioural JK bank with an
// optional stuck-bit fault. Expected j/k, done timing and err come from an
// operation-level model: a drive moves every healthy bit to the target, a
// stuck bit never moves, so an op either completes after one drive or fails
// after MAX_RETRY+1 drives.
module tb_jk_excite_driver;
  localparam int W  = 4;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic [W-1:0] bank0 = '0, bank1 = '0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] stuck_m = '0, stuck_v = '0;
  logic         err_exp = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  jk_excite_driver_if #(.WIDTH(W)) if0 ();
  jk_excite_driver_if #(.WIDTH(W)) if1 ();

  assign if0.tgt_valid = tgt_valid;
  assign if0.tgt_data  = tgt_data;
  assign if0.q_fb      = bank0;
  assign if1.tgt_valid = tgt_valid;
  assign if1.tgt_data  = tgt_data;
  assign if1.q_fb      = bank1;

  jk_excite_driver #(.WIDTH(W), .MAX_RETRY(MR), .TOGGLE_PREF(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  jk_excite_driver #(.WIDTH(W), .MAX_RETRY(MR), .TOGGLE_PREF(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  function automatic logic [W-1:0] stick(input logic [W-1:0] q);
    return (q & ~stuck_m) | (stuck_v & stuck_m);
  endfunction

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                           input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  always @(posedge clk) begin
    bank0 <= load_en ? load_val : stick(jk_next(bank0, if0.j, if0.k));
    bank1 <= load_en ? load_val : stick(jk_next(bank1, if1.j, if1.k));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [W-1:0] ja, input logic [W-1:0] ka,
                         input logic [W-1:0] jb, input logic [W-1:0] kb,
                         input logic rdy, input logic dn, input logic er);
    chk({tag, ".j0"}, 32'(if0.j), 32'(ja));
    chk({tag, ".k0"}, 32'(if0.k), 32'(ka));
    chk({tag, ".j1"}, 32'(if1.j), 32'(jb));
    chk({tag, ".k1"}, 32'(if1.k), 32'(kb));
    chk({tag, ".rdy0"}, 32'(if0.tgt_ready), 32'(rdy));
    chk({tag, ".rdy1"}, 32'(if1.tgt_ready), 32'(rdy));
    chk({tag, ".done0"}, 32'(if0.done), 32'(dn));
    chk({tag, ".done1"}, 32'(if1.done), 32'(dn));
    chk({tag, ".err0"}, 32'(if0.err), 32'(er));
    chk({tag, ".err1"}, 32'(if1.err), 32'(er));
  endtask

  // Changing bits only: set/reset pulls toward t, toggle flips.
  task automatic excite(input logic [W-1:0] q, input logic [W-1:0] t,
                        output logic [W-1:0] js, output logic [W-1:0] ks,
                        output logic [W-1:0] jt, output logic [W-1:0] kt);
    logic [W-1:0] d;
    d  = q ^ t;
    js = d & t;
    ks = d & ~t;
    jt = d;
    kt = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tgt_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      chk_all("idle", '0, '0, '0, '0, 1'b1, 1'b0, err_exp);
    end
  endtask

  task automatic preload(input logic [W-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    step();
    load_en  = 1'b0;
  endtask

  // Called at a sample point with the DUTs in IDLE. Ends at the sample point
  // of the done cycle with tgt_valid low, so a following call is accepted on
  // the very next edge (back-to-back).
  task automatic do_op(input logic [W-1:0] t);
    logic [W-1:0] f, qa, qb, js, ks, jt, kt, ja, ka, jb, kb;
    logic         fail;
    int           drives;
    f      = stick(t);
    fail   = (f != t);
    drives = fail ? MR + 1 : 1;
    qa     = bank0;
    qb     = bank1;
    chk("pre.rdy0", 32'(if0.tgt_ready), 32'(1));
    chk("pre.rdy1", 32'(if1.tgt_ready), 32'(1));
    tgt_valid = 1'b1;
    tgt_data  = t;
    for (int a = 0; a < drives; a++) begin
      step();
      // After a first drive every healthy bit already sits at the target.
      excite((a == 0) ? qa : f, t, js, ks, jt, kt);
      ja = js; ka = ks;
      excite((a == 0) ? qb : f, t, js, ks, jt, kt);
      jb = jt; kb = kt;
      chk_all("drive", ja, ka, jb, kb, 1'b0, 1'b0, 1'b0);
      // Stray offers while busy must be ignored.
      tgt_valid = 1'($urandom);
      tgt_data  = W'($urandom);
      step();
      chk_all("settle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      tgt_valid = 1'($urandom);
      tgt_data  = W'($urandom);
    end
    tgt_valid = 1'b0;
    step();
    err_exp = fail;
    chk_all("done", '0, '0, '0, '0, 1'b1, 1'b1, fail);
    chk("bank0", 32'(bank0), 32'(f));
    chk("bank1", 32'(bank1), 32'(f));
  endtask

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    idle(5);

    // set/reset: 0101 -> 0011 ; toggle: 1111 -> 0110
    preload(4'b0101);
    do_op(4'b0011);
    idle(1);
    preload(4'b1111);
    do_op(4'b0110);
    idle(1);

    // bit 0 stuck low: three drives then error; err held until next accept
    preload(4'b0000);
    stuck_m = 4'b0001;
    stuck_v = 4'b0000;
    do_op(4'b0001);
    idle(3);
    stuck_m = '0;
    do_op(4'b0101);

    // back-to-back with stray offers during busy cycles
    do_op(4'b1010);
    do_op(4'b0110);
    do_op(4'b0110);
    idle(2);

    // reset mid-DRIVE
    preload(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b1000;
    step();
    chk_all("rst.drive", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
    tgt_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    err_exp = 1'b0;
    chk_all("rst.after", '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // randomized operations with occasional stuck bits
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        stuck_m = W'(1 << $urandom_range(0, W - 1));
        stuck_v = W'($urandom);
      end else begin
        stuck_m = '0;
      end
      if ($urandom_range(0, 1) == 1) preload(W'($urandom));
      do_op(W'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
